// File: rtl/pipe_share_ctrl.sv
// Two-requester round-robin scheduler and sequencer for the 3-stage pipe
// F = ((A+B) + (C-D)) * D, with output back-pressure stall and flush/drain.
module pipe_share_ctrl #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] c0,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic [N-1:0] c1,
  input  logic [N-1:0] d1,
  output logic [1:0]   gnt,
  input  logic         flush,
  input  logic         res_ready,
  output logic         res_valid,
  output logic [N-1:0] res_f,
  output logic         res_id,
  output logic [1:0]   inflight,
  output logic         busy,
  output logic         flush_done,
  output logic [1:0]   dbg_state
);

  // Handshake: a result transfers on a rising edge where res_valid & res_ready;
  // while res_valid & ~res_ready the whole pipe freezes and gnt is forced to 0.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic         rr_ptr;
  logic         stall;
  logic         grant_ok;
  logic         issue;
  logic         sel;
  logic         drained_next;

  logic [N-1:0] op_a, op_b, op_c, op_d;

  logic         s1_valid, s1_id;
  logic [N-1:0] s1_x1, s1_x2, s1_d;
  logic         s2_valid, s2_id;
  logic [N-1:0] s2_x3, s2_d;
  logic [2*N-1:0] prod;

  assign stall    = res_valid & ~res_ready;
  assign grant_ok = ~stall & ~flush & (state != DRAIN);

  always_comb begin
    gnt = 2'b00;
    if (grant_ok) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign issue = gnt[0] | gnt[1];
  assign sel   = gnt[1];

  assign op_a = sel ? a1 : a0;
  assign op_b = sel ? b1 : b0;
  assign op_c = sel ? c1 : c0;
  assign op_d = sel ? d1 : d0;

  assign prod = {{N{1'b0}}, s2_x3} * {{N{1'b0}}, s2_d};

  // Pointer always moves to the requester that was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (issue) begin
      rr_ptr <= ~sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_x1    <= '0;
      s1_x2    <= '0;
      s1_d     <= '0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_x3    <= '0;
      s2_d     <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_f     <= '0;
    end else if (!stall) begin
      s1_valid <= issue;
      if (issue) begin
        s1_id <= sel;
        s1_x1 <= op_a + op_b;
        s1_x2 <= op_c - op_d;
        s1_d  <= op_d;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id <= s1_id;
        s2_x3 <= s1_x1 + s1_x2;
        s2_d  <= s1_d;
      end
      // Bubbles clear res_valid but leave the last result value visible.
      res_valid <= s2_valid;
      if (s2_valid) begin
        res_id <= s2_id;
        res_f  <= prod[N-1:0];
      end
    end
  end

  assign inflight = {1'b0, s1_valid} + {1'b0, s2_valid} + {1'b0, res_valid};

  // Pipe will hold nothing after this edge: no new issue and nothing moving forward.
  assign drained_next = ~stall & ~s1_valid & ~s2_valid & ~issue;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush)      state_nxt = DRAIN;
        else if (issue) state_nxt = RUN;
      end
      RUN: begin
        if (flush)             state_nxt = DRAIN;
        else if (drained_next) state_nxt = IDLE;
      end
      DRAIN: begin
        if (inflight == 2'd0)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state == DRAIN) && (inflight == 2'd0);
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_pipe_share_ctrl.sv
// Directed bench for pipe_share_ctrl: driver tasks push hand-computed results
// into an expected queue, a negedge monitor pops on every accepted result.
module tb_pipe_share_ctrl;

  localparam int N = 10;

  logic         clk;
  logic         rst;
  logic [1:0]   req;
  logic [N-1:0] a0, b0, c0, d0, a1, b1, c1, d1;
  logic [1:0]   gnt;
  logic         flush;
  logic         res_ready;
  logic         res_valid;
  logic [N-1:0] res_f;
  logic         res_id;
  logic [1:0]   inflight;
  logic         busy;
  logic         flush_done;
  logic [1:0]   dbg_state;

  logic [N:0]   exp_q[$];
  int           total;
  int           bad;

  pipe_share_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .c0(c0), .d0(d0),
    .a1(a1), .b1(b1), .c1(c1), .d1(d1),
    .gnt(gnt), .flush(flush), .res_ready(res_ready),
    .res_valid(res_valid), .res_f(res_f), .res_id(res_id),
    .inflight(inflight), .busy(busy), .flush_done(flush_done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_op0(input int a, input int b, input int c, input int d);
    a0 = a[N-1:0]; b0 = b[N-1:0]; c0 = c[N-1:0]; d0 = d[N-1:0];
  endtask

  task automatic set_op1(input int a, input int b, input int c, input int d);
    a1 = a[N-1:0]; b1 = b[N-1:0]; c1 = c[N-1:0]; d1 = d[N-1:0];
  endtask

  // One cycle, entered and left at posedge+1; ef is the hand-computed result of the grant.
  task automatic cyc(input logic [1:0] r, input logic fl, input logic rdy,
                     input logic [1:0] eg, input int ef);
    req = r; flush = fl; res_ready = rdy;
    @(negedge clk);
    chk("gnt", {30'd0, gnt}, {30'd0, eg});
    if (eg != 2'b00) exp_q.push_back({eg[1], ef[N-1:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 1'b1, 2'b00, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got id=%0d f=%0d expected none", res_id, res_f);
      end else begin
        logic [N:0] e;
        e = exp_q.pop_front();
        chk("res_id", {31'd0, res_id}, {31'd0, e[N]});
        chk("res_f", {22'd0, res_f}, {22'd0, e[N-1:0]});
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    req = 2'b00; flush = 1'b0; res_ready = 1'b1;
    set_op0(0, 0, 0, 0); set_op1(0, 0, 0, 0);
    rst = 1'b1;
    do_reset();

    // reset values
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_f", {22'd0, res_f}, 0);
    chk("rst_res_id", {31'd0, res_id}, 0);
    chk("rst_inflight", {30'd0, inflight}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_flush_done", {31'd0, flush_done}, 0);

    // single issue, latency 3
    set_op0(5, 3, 10, 2);
    cyc(2'b01, 1'b0, 1'b1, 2'b01, 32);
    chk("t1_c1_valid", {31'd0, res_valid}, 0);
    chk("t1_c1_inflight", {30'd0, inflight}, 1);
    chk("t1_c1_busy", {31'd0, busy}, 1);
    idle(1);
    chk("t1_c2_valid", {31'd0, res_valid}, 0);
    idle(1);
    chk("t1_c3_valid", {31'd0, res_valid}, 1);
    chk("t1_c3_f", {22'd0, res_f}, 32);
    chk("t1_c3_inflight", {30'd0, inflight}, 1);
    idle(1);
    chk("t1_c4_valid", {31'd0, res_valid}, 0);
    chk("t1_c4_inflight", {30'd0, inflight}, 0);
    chk("t1_c4_busy", {31'd0, busy}, 0);

    // modulo wrap
    set_op0(1000, 100, 0, 1);
    cyc(2'b01, 1'b0, 1'b1, 2'b01, 75);
    idle(2);
    chk("t2_f", {22'd0, res_f}, 75);
    idle(2);

    // contended round robin, back-to-back results
    do_reset();
    set_op0(1, 2, 3, 4); set_op1(10, 20, 30, 5);
    cyc(2'b11, 1'b0, 1'b1, 2'b01, 8);
    set_op0(100, 200, 300, 7);
    cyc(2'b11, 1'b0, 1'b1, 2'b10, 275);
    set_op1(511, 511, 0, 2);
    cyc(2'b11, 1'b0, 1'b1, 2'b01, 55);
    cyc(2'b11, 1'b0, 1'b1, 2'b10, 1016);
    for (int i = 0; i < 3; i++) begin
      chk("t3_b2b_valid", {31'd0, res_valid}, 1);
      idle(1);
    end
    chk("t3_end_valid", {31'd0, res_valid}, 0);
    idle(2);

    // back-pressure stall
    set_op0(2, 3, 4, 1);
    cyc(2'b01, 1'b0, 1'b1, 2'b01, 8);
    set_op0(50, 60, 70, 10);
    cyc(2'b01, 1'b0, 1'b1, 2'b01, 676);
    set_op0(300, 400, 500, 3);
    cyc(2'b01, 1'b0, 1'b1, 2'b01, 519);
    set_op0(1, 1, 1, 1);
    chk("t4_c3_inflight", {30'd0, inflight}, 3);
    chk("t4_c3_f", {22'd0, res_f}, 8);
    for (int i = 0; i < 2; i++) begin
      cyc(2'b01, 1'b0, 1'b0, 2'b00, 0);
      chk("t4_hold_valid", {31'd0, res_valid}, 1);
      chk("t4_hold_f", {22'd0, res_f}, 8);
      chk("t4_hold_id", {31'd0, res_id}, 0);
      chk("t4_hold_inflight", {30'd0, inflight}, 3);
    end
    idle(4);
    chk("t4_drained", {30'd0, inflight}, 0);

    // flush / drain
    set_op0(6, 6, 6, 6); set_op1(1, 1, 1, 1);
    cyc(2'b01, 1'b0, 1'b1, 2'b01, 72);
    cyc(2'b10, 1'b0, 1'b1, 2'b10, 2);
    cyc(2'b11, 1'b1, 1'b1, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_drain_busy", {31'd0, busy}, 1);
      chk("t5_drain_done", {31'd0, flush_done}, 0);
      cyc(2'b11, 1'b0, 1'b1, 2'b00, 0);
    end
    chk("t5_flush_done", {31'd0, flush_done}, 1);
    chk("t5_busy_after", {31'd0, busy}, 0);
    chk("t5_inflight_after", {30'd0, inflight}, 0);
    set_op0(9, 1, 0, 9);
    cyc(2'b11, 1'b0, 1'b1, 2'b01, 9);
    chk("t5_done_pulse", {31'd0, flush_done}, 0);
    idle(4);

    // asynchronous reset with two results in flight
    set_op0(3, 3, 3, 3);
    cyc(2'b01, 1'b0, 1'b1, 2'b01, 18);
    set_op0(4, 4, 4, 4);
    cyc(2'b01, 1'b0, 1'b1, 2'b01, 32);
    req = 2'b00;
    chk("t6_pre_inflight", {30'd0, inflight}, 2);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", {31'd0, res_valid}, 0);
    chk("t6_rst_inflight", {30'd0, inflight}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_stale", {31'd0, res_valid}, 0);
      idle(1);
    end
    set_op0(7, 9, 20, 3); set_op1(1, 2, 3, 4);
    cyc(2'b11, 1'b0, 1'b1, 2'b01, 99);
    idle(2);
    chk("t6_new_f", {22'd0, res_f}, 99);
    idle(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
